// File: rtl/csr_unit.sv
// csr_unit: executes Zicsr instructions (CSRRW/S/C and their immediate
// forms) with a single cycle of latency. The old CSR value is read
// combinationally through csr_address_r/csr_data, the new value is computed
// in the accepting cycle, and the write plus the integer-register result are
// presented for exactly one cycle afterwards.
//
// Ports
//   clk, nrst           clock, asynchronous active-low reset
//   csr_valid           decoded CSR instruction present this cycle
//   csr_op              funct3 (001 RW, 010 RS, 011 RC, 101/110/111 imm forms)
//   csr_address         target CSR
//   src_field           rs1 index or zimm
//   rs1_data            rs1 value
//   rd_addr             destination integer register
//   stall               blocks acceptance of a new op
//   flush               discards the op being accepted this cycle
//   csr_data            CSR read data for csr_address_r
//   csr_address_r       CSR read address (follows csr_address)
//   csr_address_wb      CSR write address (IDLE_ADDR when nothing is written)
//   csr_wb              CSR write data
//   rd_wdata            old CSR value for the integer register file
//   rd_addr_wb          registered rd_addr
//   rd_we               integer register write enable
//   illegal_csr         one-cycle illegal-instruction pulse
//   csr_hazard          op held off because it targets the CSR being written
module csr_unit #(
  parameter int          XLEN      = 32,
  parameter logic [11:0] IDLE_ADDR = 12'h000
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            csr_valid,
  input  logic [2:0]      csr_op,
  input  logic [11:0]     csr_address,
  input  logic [4:0]      src_field,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      rd_addr,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] csr_data,
  output logic [11:0]     csr_address_r,
  output logic [11:0]     csr_address_wb,
  output logic [XLEN-1:0] csr_wb,
  output logic [XLEN-1:0] rd_wdata,
  output logic [4:0]      rd_addr_wb,
  output logic            rd_we,
  output logic            illegal_csr,
  output logic            csr_hazard
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state_q, state_d;

  // Registered results, visible during the cycle after acceptance.
  logic [11:0]     addr_wb_p1, addr_wb_d;
  logic [XLEN-1:0] wb_p1, wb_d;
  logic [XLEN-1:0] rd_wdata_p1, rd_wdata_d;
  logic [4:0]      rd_addr_p1, rd_addr_d;
  logic            rd_we_p1, rd_we_d;
  logic            illegal_p1, illegal_d;
  logic            wr_p1, wr_d;

  logic [XLEN-1:0] src_val;
  logic            wr_intent;
  logic            illegal_op;
  logic            accept;

  // kind is csr_op[1:0]: 01 write, 10 set bits, 11 clear bits.
  function automatic logic [XLEN-1:0] csr_new_value(
    input logic [1:0]      kind,
    input logic [XLEN-1:0] old_val,
    input logic [XLEN-1:0] src
  );
    logic [XLEN-1:0] res;
    case (kind)
      2'b10:   res = old_val | src;
      2'b11:   res = old_val & ~src;
      default: res = src;
    endcase
    return res;
  endfunction

  assign csr_address_r = csr_address;

  // ---- stage p0: decode and accept in the presenting cycle ----
  assign src_val    = csr_op[2] ? {{(XLEN-5){1'b0}}, src_field} : rs1_data;
  // Set/clear with a zero source are pure reads and never write the CSR.
  assign wr_intent  = (csr_op[1:0] == 2'b01) || (src_field != 5'd0);
  // Reads of the read-only space (addr[11:10]==11) are legal; writes are not.
  assign illegal_op = (csr_op[1:0] == 2'b00) ||
                      (wr_intent && (csr_address[11:10] == 2'b11));

  // Only an actual write on the outputs can conflict; the op is held one
  // cycle so it reads the CSR value after this write has landed.
  assign csr_hazard = (state_q == ISSUE) && wr_p1 && csr_valid &&
                      (csr_address == addr_wb_p1);

  // A flushed op is simply not taken; the write already issuing is untouched.
  assign accept = csr_valid && !stall && !csr_hazard && !flush;

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (accept) state_d = ISSUE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_wb_d  = IDLE_ADDR;
    wb_d       = '0;
    rd_wdata_d = '0;
    rd_we_d    = 1'b0;
    illegal_d  = 1'b0;
    wr_d       = 1'b0;
    rd_addr_d  = rd_addr_p1;
    if (accept) begin
      rd_addr_d = rd_addr;
      if (illegal_op) begin
        illegal_d = 1'b1;
      end else begin
        rd_wdata_d = csr_data;
        rd_we_d    = (rd_addr != 5'd0);
        if (wr_intent) begin
          wr_d      = 1'b1;
          addr_wb_d = csr_address;
          wb_d      = csr_new_value(csr_op[1:0], csr_data, src_val);
        end
      end
    end
  end

  // ---- stage p1: results registered, presented for one cycle ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      addr_wb_p1  <= IDLE_ADDR;
      wb_p1       <= '0;
      rd_wdata_p1 <= '0;
      rd_addr_p1  <= '0;
      rd_we_p1    <= 1'b0;
      illegal_p1  <= 1'b0;
      wr_p1       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_wb_p1  <= addr_wb_d;
      wb_p1       <= wb_d;
      rd_wdata_p1 <= rd_wdata_d;
      rd_addr_p1  <= rd_addr_d;
      rd_we_p1    <= rd_we_d;
      illegal_p1  <= illegal_d;
      wr_p1       <= wr_d;
    end
  end

  assign csr_address_wb = addr_wb_p1;
  assign csr_wb         = wb_p1;
  assign rd_wdata       = rd_wdata_p1;
  assign rd_addr_wb     = rd_addr_p1;
  assign rd_we          = rd_we_p1;
  assign illegal_csr    = illegal_p1;

endmodule

// File: tb/tb_csr_unit.sv
module tb_csr_unit;

  localparam int          XLEN      = 32;
  localparam logic [11:0] IDLE_ADDR = 12'h000;

  logic            clk = 1'b0;
  logic            nrst = 1'b1;
  logic            csr_valid = 1'b0;
  logic [2:0]      csr_op = '0;
  logic [11:0]     csr_address = '0;
  logic [4:0]      src_field = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [4:0]      rd_addr = '0;
  logic            stall = 1'b0;
  logic            flush = 1'b0;
  logic [XLEN-1:0] csr_data;
  logic [11:0]     csr_address_r;
  logic [11:0]     csr_address_wb;
  logic [XLEN-1:0] csr_wb;
  logic [XLEN-1:0] rd_wdata;
  logic [4:0]      rd_addr_wb;
  logic            rd_we;
  logic            illegal_csr;
  logic            csr_hazard;

  int checks = 0;
  int errors = 0;

  // Bench-side CSR register file, updated only from the expected writes.
  logic [31:0] csr_file [0:4095];
  assign csr_data = csr_file[csr_address_r];

  typedef struct {
    logic [11:0] addr_wb;
    logic [31:0] wb;
    logic [31:0] rdw;
    logic        rd_we;
    logic        ill;
    logic        wr;
    logic        chk_rd;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  csr_unit #(.XLEN(XLEN), .IDLE_ADDR(IDLE_ADDR)) dut (
    .clk(clk), .nrst(nrst), .csr_valid(csr_valid), .csr_op(csr_op),
    .csr_address(csr_address), .src_field(src_field), .rs1_data(rs1_data),
    .rd_addr(rd_addr), .stall(stall), .flush(flush), .csr_data(csr_data),
    .csr_address_r(csr_address_r), .csr_address_wb(csr_address_wb),
    .csr_wb(csr_wb), .rd_wdata(rd_wdata), .rd_addr_wb(rd_addr_wb),
    .rd_we(rd_we), .illegal_csr(illegal_csr), .csr_hazard(csr_hazard)
  );

  function automatic exp_t idle_exp();
    exp_t e;
    e.addr_wb = IDLE_ADDR; e.wb = '0; e.rdw = '0; e.rd_we = 1'b0;
    e.ill = 1'b0; e.wr = 1'b0; e.chk_rd = 1'b0; e.rd = '0;
    return e;
  endfunction

  // One clock cycle: check the outputs owed from the previous cycle, drive
  // the new inputs, check the hazard flag, queue what the next cycle owes.
  task automatic step(input logic v, input logic [2:0] op, input logic [11:0] a,
                      input logic [4:0] src, input logic [31:0] r1,
                      input logic [4:0] rd, input logic st, input logic fl,
                      input logic exp_acc, input logic exp_hz, input string tag);
    exp_t e, n;
    logic [31:0] old_v, s;
    logic intent, ill;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      checks++;
      if (csr_address_wb !== e.addr_wb) begin
        errors++; $display("FAIL %s csr_address_wb got %h want %h", tag, csr_address_wb, e.addr_wb);
      end
      checks++;
      if (csr_wb !== e.wb) begin
        errors++; $display("FAIL %s csr_wb got %h want %h", tag, csr_wb, e.wb);
      end
      checks++;
      if (rd_wdata !== e.rdw) begin
        errors++; $display("FAIL %s rd_wdata got %h want %h", tag, rd_wdata, e.rdw);
      end
      checks++;
      if (rd_we !== e.rd_we) begin
        errors++; $display("FAIL %s rd_we got %b want %b", tag, rd_we, e.rd_we);
      end
      checks++;
      if (illegal_csr !== e.ill) begin
        errors++; $display("FAIL %s illegal_csr got %b want %b", tag, illegal_csr, e.ill);
      end
      if (e.chk_rd) begin
        checks++;
        if (rd_addr_wb !== e.rd) begin
          errors++; $display("FAIL %s rd_addr_wb got %0d want %0d", tag, rd_addr_wb, e.rd);
        end
      end
      if (e.wr) csr_file[e.addr_wb] = e.wb;
    end
    csr_valid = v; csr_op = op; csr_address = a; src_field = src;
    rs1_data = r1; rd_addr = rd; stall = st; flush = fl;
    #1;
    checks++;
    if (csr_hazard !== exp_hz) begin
      errors++; $display("FAIL %s csr_hazard got %b want %b", tag, csr_hazard, exp_hz);
    end
    checks++;
    if (csr_address_r !== a) begin
      errors++; $display("FAIL %s csr_address_r got %h want %h", tag, csr_address_r, a);
    end
    n = idle_exp();
    if (exp_acc && !fl) begin
      old_v  = csr_file[a];
      s      = op[2] ? {27'b0, src} : r1;
      intent = (op[1:0] == 2'b01) || (src != 5'd0);
      ill    = (op[1:0] == 2'b00) || (intent && (a[11:10] == 2'b11));
      n.chk_rd = 1'b1;
      n.rd     = rd;
      if (ill) begin
        n.ill = 1'b1;
      end else begin
        n.rdw   = old_v;
        n.rd_we = (rd != 5'd0);
        if (intent) begin
          n.wr = 1'b1;
          n.addr_wb = a;
          case (op[1:0])
            2'b10:   n.wb = old_v | s;
            2'b11:   n.wb = old_v & ~s;
            default: n.wb = s;
          endcase
        end
      end
    end
    sb.push_back(n);
    @(posedge clk); #1;
  endtask

  task automatic idle_step(input string tag);
    step(1'b0, 3'b000, 12'h000, 5'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic test_reset();
    #1 nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (csr_address_wb !== IDLE_ADDR) begin errors++; $display("FAIL reset csr_address_wb got %h want %h", csr_address_wb, IDLE_ADDR); end
    checks++;
    if (csr_wb !== 32'h0) begin errors++; $display("FAIL reset csr_wb got %h want 0", csr_wb); end
    checks++;
    if (rd_wdata !== 32'h0) begin errors++; $display("FAIL reset rd_wdata got %h want 0", rd_wdata); end
    checks++;
    if (rd_addr_wb !== 5'd0) begin errors++; $display("FAIL reset rd_addr_wb got %0d want 0", rd_addr_wb); end
    checks++;
    if ({rd_we, illegal_csr, csr_hazard} !== 3'b000) begin
      errors++; $display("FAIL reset flags got %b want 000", {rd_we, illegal_csr, csr_hazard});
    end
    nrst = 1'b1;
    sb.push_back(idle_exp());
  endtask

  task automatic test_basic_ops();
    // CSRRW in the very first cycle after reset release.
    step(1'b1, 3'b001, 12'h340, 5'd1, 32'hDEADBEEF, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, "csrrw");
    checks++;
    if (csr_address_wb !== 12'h340 || csr_wb !== 32'hDEADBEEF || rd_wdata !== 32'h1234 || rd_we !== 1'b1) begin
      errors++; $display("FAIL csrrw_vec got %h %h %h %b want 340 deadbeef 00001234 1", csr_address_wb, csr_wb, rd_wdata, rd_we);
    end
    step(1'b1, 3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0, "csrrs_x0");
    checks++;
    if (csr_address_wb !== IDLE_ADDR || rd_wdata !== 32'h88 || illegal_csr !== 1'b0) begin
      errors++; $display("FAIL csrrs_x0_vec got %h %h %b want %h 00000088 0", csr_address_wb, rd_wdata, illegal_csr, IDLE_ADDR);
    end
    step(1'b1, 3'b111, 12'h304, 5'h08, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, "csrrci");
    checks++;
    if (csr_wb !== 32'h880 || csr_address_wb !== 12'h304) begin
      errors++; $display("FAIL csrrci_vec got %h %h want 304 00000880", csr_address_wb, csr_wb);
    end
    step(1'b1, 3'b001, 12'hF14, 5'd2, 32'h5555, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, "ro_write");
    checks++;
    if (illegal_csr !== 1'b1 || rd_we !== 1'b0 || csr_address_wb !== IDLE_ADDR) begin
      errors++; $display("FAIL ro_write_vec got %b %b %h want 1 0 %h", illegal_csr, rd_we, csr_address_wb, IDLE_ADDR);
    end
    step(1'b1, 3'b100, 12'h340, 5'd3, 32'h1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, "bad_funct3");
    step(1'b1, 3'b110, 12'h341, 5'd3, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "csrrsi_rd0");
    step(1'b1, 3'b010, 12'hC00, 5'd0, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, "ro_read");
    idle_step("basic_tail");
  endtask

  task automatic test_back_to_back();
    step(1'b1, 3'b010, 12'h340, 5'd1, 32'h0000_0F00, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_first");
    step(1'b1, 3'b010, 12'h340, 5'd1, 32'h0000_0F00, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1, "b2b_held");
    step(1'b1, 3'b010, 12'h340, 5'd1, 32'h0000_0F00, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_second");
    checks++;
    if (rd_wdata !== 32'hDEADBFEF) begin
      errors++; $display("FAIL b2b_reread rd_wdata got %h want deadbfef", rd_wdata);
    end
    idle_step("b2b_tail");
  endtask

  task automatic test_stall();
    step(1'b1, 3'b001, 12'h305, 5'd1, 32'hA5A5_A5A5, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0, "stall_op");
    step(1'b1, 3'b001, 12'h305, 5'd1, 32'h1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, "stall_c1");
    step(1'b1, 3'b001, 12'h305, 5'd1, 32'h1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, "stall_c2");
    step(1'b1, 3'b001, 12'h305, 5'd1, 32'h1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, "stall_c3");
    idle_step("stall_tail");
  endtask

  task automatic test_flush();
    step(1'b1, 3'b001, 12'h307, 5'd1, 32'h1111_1111, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, "flush_first");
    step(1'b1, 3'b001, 12'h308, 5'd1, 32'h2222_2222, 5'd13, 1'b0, 1'b1, 1'b0, 1'b0, "flush_drop");
    idle_step("flush_t1");
    idle_step("flush_t2");
  endtask

  task automatic test_reset_mid_issue();
    step(1'b1, 3'b001, 12'h309, 5'd1, 32'h3333_3333, 5'd14, 1'b0, 1'b0, 1'b1, 1'b0, "rst_op");
    csr_valid = 1'b0;
    nrst = 1'b0;
    #1;
    checks++;
    if (csr_address_wb !== IDLE_ADDR || csr_wb !== 32'h0) begin
      errors++; $display("FAIL rst_mid write got %h %h want %h 0", csr_address_wb, csr_wb, IDLE_ADDR);
    end
    checks++;
    if (rd_wdata !== 32'h0 || rd_we !== 1'b0 || illegal_csr !== 1'b0 || rd_addr_wb !== 5'd0) begin
      errors++; $display("FAIL rst_mid rd got %h %b %b %0d want 0 0 0 0", rd_wdata, rd_we, illegal_csr, rd_addr_wb);
    end
    sb.delete();
    @(posedge clk); #1;
    nrst = 1'b1;
    sb.push_back(idle_exp());
    step(1'b1, 3'b001, 12'h309, 5'd1, 32'h4444_4444, 5'd15, 1'b0, 1'b0, 1'b1, 1'b0, "rst_after");
    idle_step("rst_tail");
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) csr_file[i] = 32'h0;
    csr_file[12'h340] = 32'h1234;
    csr_file[12'h300] = 32'h88;
    csr_file[12'h304] = 32'h888;
    csr_file[12'h341] = 32'h10;
    csr_file[12'hC00] = 32'hCAFE;
    test_reset();
    test_basic_ops();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
